// File: rtl/ds_adc_pkg.sv
// Shared constants for the delta-sigma ADC datapath.
// The CIC register width follows from filter order and decimation ratio.
package ds_adc_pkg;

  localparam int CIC_ORDER    = 3;
  localparam int DEF_R_LOG2   = 6;
  localparam int WARMUP_WORDS = 3;

  // Bit growth of an order-N CIC is N*log2(R); one extra bit holds exactly R^N.
  function automatic int cic_width(input int r_log2);
    return CIC_ORDER * r_log2 + 1;
  endfunction

endpackage

// File: rtl/ds_cic_integrator.sv
// Single CIC integrator stage: one W-bit accumulator that wraps modulo 2^W.
// sum_o presents the accumulator value including this cycle's input.
module ds_cic_integrator #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] sum_o
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      acc_d = acc_q + data_i;
    end
  end

  assign sum_o = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/ds_cic_decimator.sv
// Sinc3 decimator for the modulator bitstream: three integrators, decimating
// comb chain, warm-up suppression and a one-word valid/ready holding register.
module ds_cic_decimator
  import ds_adc_pkg::*;
#(
  parameter  int R_LOG2 = DEF_R_LOG2,
  localparam int W      = cic_width(R_LOG2)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         bit_in,
  input  logic         bit_vld,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overrun
);

  localparam int WARM_W = $clog2(WARMUP_WORDS + 1);

  logic              sample_en;
  logic              tick;
  logic              load;
  logic              deliver;
  logic              warm_done;
  logic [R_LOG2-1:0] count_q, count_d;
  logic [W-1:0]      integ_in  [CIC_ORDER];
  logic [W-1:0]      integ_sum [CIC_ORDER];
  logic [W-1:0]      comb_stage[CIC_ORDER+1];
  logic [W-1:0]      comb_q, comb_d;
  logic              comb_vld_q, comb_vld_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [W-1:0]      out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;

  assign sample_en = en & bit_vld;
  assign tick      = sample_en & (count_q == {R_LOG2{1'b1}});
  assign count_d   = sample_en ? count_q + R_LOG2'(1) : count_q;

  // Each stage accumulates the freshly updated value of the stage before it.
  generate
    for (genvar gi = 0; gi < CIC_ORDER; gi++) begin : g_integ
      if (gi == 0) begin : g_first
        assign integ_in[gi] = {{(W-1){1'b0}}, bit_in};
      end else begin : g_chain
        assign integ_in[gi] = integ_sum[gi-1];
      end
      ds_cic_integrator #(.W(W)) u_integ (
        .clk   (clk),
        .rst   (rst),
        .en_i  (sample_en),
        .data_i(integ_in[gi]),
        .sum_o (integ_sum[gi])
      );
    end
  endgenerate

  assign comb_stage[0] = integ_sum[CIC_ORDER-1];

  generate
    for (genvar gi = 0; gi < CIC_ORDER; gi++) begin : g_comb
      logic [W-1:0] dly_q;
      assign comb_stage[gi+1] = comb_stage[gi] - dly_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dly_q <= '0;
        end else if (tick) begin
          dly_q <= comb_stage[gi];
        end
      end
    end
  endgenerate

  assign comb_d     = tick ? comb_stage[CIC_ORDER] : comb_q;
  // A pending comb word waits out any en=0 stretch before loading.
  assign comb_vld_d = en ? tick : comb_vld_q;

  assign load      = en & comb_vld_q;
  assign warm_done = (warm_q == WARM_W'(WARMUP_WORDS));
  assign deliver   = load & warm_done;
  assign warm_d    = (load & ~warm_done) ? warm_q + WARM_W'(1) : warm_q;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (deliver) begin
      out_data_d  = comb_q;
      out_valid_d = 1'b1;
      if (out_valid_q & ~out_ready) begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      comb_q      <= '0;
      comb_vld_q  <= 1'b0;
      warm_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      comb_q      <= comb_d;
      comb_vld_q  <= comb_vld_d;
      warm_q      <= warm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_ds_cic_decimator.sv
// Bench for ds_cic_decimator: constant-pattern table, timing/handshake/reset
// sequences, and random streams checked against a direct sinc3 convolution.
module tb_ds_cic_decimator;

  localparam int R_LOG2 = 6;
  localparam int R      = 64;
  localparam int W      = 19;
  localparam int KLEN   = 3 * R - 2;
  localparam int NS     = 8 * R;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         bit_in;
  logic         bit_vld;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  int h[KLEN];
  bit xs[$];
  int exp_q[$];
  int got_q[$];
  int got_a[$];
  bit seq[NS];
  int step_no;
  int first_valid_step;

  typedef struct {
    string name;
    int    mode;
    bit    gaps;
    int    exp_word;
    int    exp_count;
  } vec_t;

  vec_t tbl[5];

  ds_cic_decimator #(.R_LOG2(R_LOG2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bit_in   (bit_in),
    .bit_vld  (bit_vld),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: word = sinc3 kernel (box R convolved thrice) applied to the
  // sample history ending at the R-th sample of each frame; first 3 dropped.
  function automatic void model_feed(input bit b);
    int n;
    longint y;
    n = xs.size();
    xs.push_back(b);
    if ((n % R) == R - 1 && (n / R) >= 3) begin
      y = 0;
      for (int j = 0; j < KLEN; j++) begin
        if (n - j >= 0) y += longint'(h[j]) * longint'(xs[n-j]);
      end
      exp_q.push_back(int'(y % (longint'(1) << W)));
    end
  endfunction

  function automatic bit pat(input int mode, input int k);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return (k % 2) == 0;
  endfunction

  task automatic step(input bit vld, input bit b);
    bit_vld = vld;
    bit_in  = b;
    @(posedge clk);
    #1;
    step_no++;
    if (en && vld) model_feed(b);
    if (out_valid && first_valid_step < 0) first_valid_step = step_no;
    if (out_valid && out_ready) begin
      got_q.push_back(int'(out_data));
      $display("word %0d at step %0d: %0d", got_q.size(), step_no, out_data);
    end
  endtask

  task automatic do_reset();
    en        = 1'b0;
    bit_vld   = 1'b0;
    bit_in    = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;
    xs.delete();
    exp_q.delete();
    got_q.delete();
    step_no          = 0;
    first_valid_step = -1;
  endtask

  task automatic flush();
    repeat (4) step(1'b0, 1'b0);
  endtask

  task automatic compare_words(input string name);
    chk({name, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk(name, got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    for (int j = 0; j < KLEN; j++) h[j] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++)
          h[a+b+c]++;

    tbl[0] = '{"zeros",     0, 1'b0, 0,      4};
    tbl[1] = '{"ones",      1, 1'b0, 262144, 4};
    tbl[2] = '{"alt",       2, 1'b0, 131072, 4};
    tbl[3] = '{"alt_gaps",  2, 1'b1, 131072, 4};
    tbl[4] = '{"ones_gaps", 1, 1'b1, 262144, 4};

    do_reset();
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset overrun", overrun, 0);

    // Constant patterns: 7 frames give words 4..7.
    for (int t = 0; t < 5; t++) begin
      int k;
      do_reset();
      k = 0;
      while (k < 7 * R) begin
        if (tbl[t].gaps && $urandom_range(2) == 0) begin
          step(1'b0, 1'b0);
        end else begin
          step(1'b1, pat(tbl[t].mode, k));
          k++;
        end
      end
      flush();
      chk({tbl[t].name, " count"}, got_q.size(), tbl[t].exp_count);
      foreach (got_q[i]) chk(tbl[t].name, got_q[i], tbl[t].exp_word);
      chk({tbl[t].name, " overrun"}, overrun, 0);
    end

    // First delivered word: tick on sample 4R, visible two edges later.
    do_reset();
    repeat (4 * R + 3) step(1'b1, 1'b0);
    chk("first valid step", first_valid_step, 4 * R + 1);

    // Overrun: consumer stalled across two loads, then drains.
    do_reset();
    out_ready = 1'b0;
    repeat (4 * R + 1) step(1'b1, 1'b1);
    chk("stall first load valid", out_valid, 1);
    chk("stall first load overrun", overrun, 0);
    repeat (R) step(1'b1, 1'b1);
    chk("stall second load data", out_data, 262144);
    chk("stall second load overrun", overrun, 1);
    out_ready = 1'b1;
    step(1'b1, 1'b1);
    chk("drain valid", out_valid, 0);
    chk("drain overrun sticky", overrun, 1);

    // Asynchronous reset mid-frame with a stalled word and overrun pending.
    do_reset();
    out_ready = 1'b0;
    repeat (5 * R + 30) step(1'b1, 1'b1);
    chk("pre-reset overrun", overrun, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset out_valid", out_valid, 0);
    chk("async reset out_data", out_data, 0);
    chk("async reset overrun", overrun, 0);
    do_reset();
    repeat (4 * R + 3) step(1'b1, 1'b1);
    chk("post-reset first valid step", first_valid_step, 4 * R + 1);

    // Random stream, uninterrupted, against the reference.
    for (int i = 0; i < NS; i++) seq[i] = 1'($urandom_range(1));
    do_reset();
    for (int i = 0; i < NS; i++) begin
      if ($urandom_range(3) == 0) step(1'b0, 1'b0);
      step(1'b1, seq[i]);
    end
    flush();
    compare_words("random run");
    got_a = got_q;

    // Same stream with a 100-cycle en=0 stretch right after a tick.
    do_reset();
    for (int i = 0; i < NS; i++) begin
      step(1'b1, seq[i]);
      if (i == 5 * R - 1) begin
        logic [W-1:0] held;
        held = out_data;
        en   = 1'b0;
        for (int c = 0; c < 100; c++) step(1'(c % 2), 1'($urandom_range(1)));
        chk("freeze out_data", out_data, held);
        chk("freeze out_valid", out_valid, 0);
        en = 1'b1;
      end
    end
    flush();
    compare_words("frozen run");
    chk("frozen vs plain count", got_q.size(), got_a.size());
    for (int i = 0; i < got_q.size() && i < got_a.size(); i++) begin
      chk("frozen vs plain", got_q[i], got_a[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
